// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use a shift-add over a 64-bit accumulator, DIV/DIVU use
// restoring division; both work on magnitudes and fix up signs in a final
// FIX cycle. Every operation takes 33 cycles after the accepting edge.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enable,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   r_opb;      // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   r_a_raw;    // untouched dividend, returned in HI on divide-by-zero
  logic              r_is_div;
  logic              r_neg_q;    // negate product / quotient
  logic              r_neg_r;    // negate remainder
  logic              r_div_zero;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;

  logic              w_busy;
  logic              w_accept;
  logic              w_calc;
  logic              w_fix;
  logic              w_mt_ok;

  // ---------------- operand conditioning ----------------
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[XLEN-1];
  assign w_b_neg  = w_signed & b[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN+1:0]   w_div_diff;
  logic              w_div_ok;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_next;

  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
  assign w_div_ok    = ~w_div_diff[XLEN+1];
  assign w_div_rem   = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
  assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ok};

  // ---------------- sign fix-up ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  // Pick the value written to HI/LO at the end of an operation
  always_comb begin
    w_fix_hi = w_prod[2*XLEN-1:XLEN];
    w_fix_lo = w_prod[XLEN-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = {XLEN{1'b1}};
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quot;
      end
    end
  end

  // ---------------- FSM ----------------
  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (clk_enable) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(ITER - 1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM-derived control strobes
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) & start;
    w_calc   = (r_state == S_CALC);
    w_fix    = (r_state == S_FIX);
    w_mt_ok  = (r_state == S_IDLE) & ~start;
  end

  // ---------------- datapath ----------------
  // Latch operands on accept, then iterate once per enabled edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_a_raw    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (clk_enable) begin
      if (w_accept) begin
        r_cnt      <= '0;
        r_is_div   <= op[1];
        r_a_raw    <= a;
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        r_div_zero <= op[1] & (b == '0);
        if (op[1]) begin
          r_acc <= {{XLEN{1'b0}}, w_a_mag};
          r_opb <= w_b_mag;
        end else begin
          r_acc <= {{XLEN{1'b0}}, w_b_mag};
          r_opb <= w_a_mag;
        end
      end else if (w_calc) begin
        r_acc <= r_is_div ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // HI/LO: written by a finishing op, or by MTHI/MTLO only when idle without start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (clk_enable) begin
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_mt_ok) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  // Done pulse registered so it holds while the clock enable is low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (clk_enable) begin
      r_done <= w_fix;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = w_busy;
  assign done = r_done;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the Harvard MIPS core. It sits downstream of the register file and consumes the rs/rt read data (rd1/rd2) for MULT, MULTU, DIV and DIVU. It also serves MTHI/MTLO writes and MFHI/MFLO reads. While an operation is in flight, busy stalls the pipeline.

Parameters:
XLEN, 32, operand/HI/LO width
ITER, 32, iteration cycles per operation (equals XLEN; not independently tunable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
clk_enable  input  1  when low, all state frozen (halt)
start  input  1  request operation, sampled at rising edge
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  XLEN  rs operand (dividend / multiplicand)
b  input  XLEN  rt operand (divisor / multiplier)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  XLEN  MTHI/MTLO data
hi  output  XLEN  HI register
lo  output  XLEN  LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse, HI/LO just updated by an op

Behaviour:
- Reset (sync, edge with reset=1): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides clk_enable and aborts any operation mid-flight; no partial result is written.
- clk_enable=0: no state, counter, HI/LO or done change; done holds its value.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 at edge T0:
  - latch |a|, |b| (signed ops) or a, b raw (unsigned ops), plus result sign flags.
  - counter=0, state→CALC, busy=1 after T0.
- CALC: one iteration per edge, at T1..T32.
  - Multiply: shift-add over 64-bit accumulator.
  - Divide: restoring, one quotient bit per edge.
  - At T32 (counter=31), state→FIX.
- FIX, edge T33:
  - apply signs; write hi/lo; done=1 for exactly one cycle; busy=0; state→IDLE.
  - busy is high for exactly 33 cycles after the accepting edge.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. Signed product negated when sign(a) XOR sign(b).
  - DIV/DIVU: lo=quotient, hi=remainder. Signed: quotient negative iff signs differ; remainder takes dividend's sign (truncating division).
  - Overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): same 33-cycle latency; lo=0xFFFFFFFF, hi=original a.
- hi/lo hold previous values throughout CALC/FIX; they change only at FIX or MTHI/MTLO.
- start while busy: ignored, no queuing.
- mthi/mtlo in IDLE without start: write wdata on the edge. Both asserted together: both registers written.
- mthi/mtlo while busy: ignored.
- start and mthi/mtlo in the same IDLE cycle: start wins, writes ignored.
- Back-to-back: start may be accepted in the cycle where done=1 (state is IDLE).

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles, done pulse once, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU a=0x1234 b=0 -> after 33 cycles lo=0xFFFFFFFF hi=0x1234.
- MTHI wdata=0xAAAA5555 in IDLE -> hi=0xAAAA5555 next edge. Then start MULTU 3×4 and pulse mtlo (wdata=0xDEAD) plus a second start at cycle 5 -> both ignored; final hi=0 lo=12.
- Start DIVU, assert reset at cycle 10 -> next edge hi=lo=0, busy=0, done never pulses. Separately, clk_enable=0 for 5 cycles mid-op -> busy extends by exactly 5 cycles, result unchanged.
